// File: rtl/core_sequencer.sv
// core_sequencer: fetches 16-bit words from instruction memory and issues them to the core array.
// Optional feature macro SEQ_LOOP_EN adds the loop counter; without it LOOP_SET/LOOP_BACK are NOPs.
`timescale 1ns/1ps
module core_sequencer #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LOOP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stall,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [15:0]           imem_data,
    output logic [15:0]           opcode,
    output logic                  execute,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StIssue = 2'd2
    } state_e;

    localparam logic [1:0] ClassLocal = 2'b10;
    localparam logic [1:0] OpHalt     = 2'b00;
    localparam logic [1:0] OpJump     = 2'b01;
    localparam logic [1:0] OpLoopSet  = 2'b10;
    localparam logic [1:0] OpLoopBack = 2'b11;

    if (LOOP_WIDTH == 0 || LOOP_WIDTH > 12) begin : g_loop_width_check
        $error("core_sequencer: LOOP_WIDTH must be in 1..12");
    end

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] jump_target;
    logic [15:0]           ir_q, ir_d;
    logic [15:0]           opcode_q, opcode_d;
    logic                  imem_req_q, imem_req_d;
    logic                  execute_q, execute_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  is_local;
    logic [1:0]            local_op;
    logic                  fetch_ack;
    logic                  unused_ir;

    assign is_local    = (ir_q[15:14] == ClassLocal);
    assign local_op    = ir_q[13:12];
    // An ack only counts while a request is actually outstanding.
    assign fetch_ack   = imem_req_q && imem_ack;
    assign pc_inc      = pc_q + ADDR_WIDTH'(1);
    assign jump_target = ir_q[ADDR_WIDTH-1:0];
    assign unused_ir   = ^ir_q;

`ifdef SEQ_LOOP_EN
    logic [LOOP_WIDTH-1:0] loop_q, loop_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loop_q <= '0;
        end else begin
            loop_q <= loop_d;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (fetch_ack) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (is_local) begin
                    state_d = (local_op == OpHalt) ? StIdle : StFetch;
                end else if (!stall) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the datapath and registered outputs
    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        opcode_d   = opcode_q;
        execute_d  = 1'b0;
        done_d     = 1'b0;
        imem_req_d = (state_d == StFetch);
        busy_d     = (state_d != StIdle);
`ifdef SEQ_LOOP_EN
        loop_d     = loop_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pc_d = '0;
                end
            end
            StFetch: begin
                if (fetch_ack) begin
                    ir_d = imem_data;
                end
            end
            StIssue: begin
                if (is_local) begin
                    unique case (local_op)
                        OpHalt: begin
                            done_d = 1'b1;
                        end
                        OpJump: begin
                            pc_d = jump_target;
                        end
                        OpLoopSet: begin
`ifdef SEQ_LOOP_EN
                            loop_d = ir_q[LOOP_WIDTH-1:0];
`endif
                            pc_d = pc_inc;
                        end
                        OpLoopBack: begin
`ifdef SEQ_LOOP_EN
                            if (loop_q != '0) begin
                                loop_d = loop_q - 1'b1;
                                pc_d   = jump_target;
                            end else begin
                                pc_d = pc_inc;
                            end
`else
                            pc_d = pc_inc;
`endif
                        end
                        default: pc_d = pc_inc;
                    endcase
                end else if (!stall) begin
                    opcode_d  = ir_q;
                    execute_d = 1'b1;
                    pc_d      = pc_inc;
                end
            end
            default: begin
                pc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            ir_q       <= '0;
            opcode_q   <= '0;
            imem_req_q <= 1'b0;
            execute_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            opcode_q   <= opcode_d;
            imem_req_q <= imem_req_d;
            execute_q  <= execute_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign opcode    = opcode_q;
    assign execute   = execute_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: table of programs plus hand-written stall, reset and
// address-wrap sequences; issued opcodes are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        imem_req, imem_ack, execute, busy, done;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data, opcode;
    logic [15:0] mem [256];
    int          ack_wait;
    int          req_cnt;

    logic        rst4_n = 1'b0;
    logic        start4 = 1'b0;
    logic        stall4 = 1'b0;
    logic        req4, ack4, exec4, busy4, done4;
    logic [3:0]  addr4;
    logic [15:0] data4, opcode4;
    logic [15:0] mem4 [16];

    always #5 clk = ~clk;

    core_sequencer #(.ADDR_WIDTH(8), .LOOP_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stall     (stall),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .opcode    (opcode),
        .execute   (execute),
        .busy      (busy),
        .done      (done)
    );

    core_sequencer #(.ADDR_WIDTH(4), .LOOP_WIDTH(8)) dut4 (
        .clk       (clk),
        .rst_n     (rst4_n),
        .start     (start4),
        .stall     (stall4),
        .imem_req  (req4),
        .imem_addr (addr4),
        .imem_ack  (ack4),
        .imem_data (data4),
        .opcode    (opcode4),
        .execute   (exec4),
        .busy      (busy4),
        .done      (done4)
    );

    // Memory model: ack after ack_wait cycles of continuous request.
    assign imem_ack  = imem_req && (req_cnt >= ack_wait);
    assign imem_data = mem[imem_addr];
    assign ack4      = req4;
    assign data4     = mem4[addr4];

    always @(posedge clk) begin
        if (imem_req && !imem_ack) req_cnt <= req_cnt + 1;
        else                       req_cnt <= 0;
    end

    typedef struct packed {
        logic [7:0][15:0] prog;
        logic [3:0]       n_words;
        logic [3:0]       ack_wait;
        logic [7:0][15:0] ops;
        logic [3:0]       n_ops;
        logic [7:0]       n_fetch;
    } vec_t;

    localparam int NumVecs = 6;
    vec_t vecs [NumVecs];

    int          n_checks = 0;
    int          n_fail = 0;
    int          exec_cnt, fetch_cnt, done_cnt;
    logic [15:0] exp_q [$];
    logic [7:0]  fetch_log [$];
    logic [3:0]  f4_log [$];
    logic [15:0] x4_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (imem_req && imem_ack) begin
            fetch_cnt++;
            fetch_log.push_back(imem_addr);
        end
        if (execute) begin
            exec_cnt++;
            check("sb_has_entry", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("exec_opcode", 32'(opcode), 32'(exp_q.pop_front()));
        end
        if (done) done_cnt++;
        if (req4) f4_log.push_back(addr4);
        if (exec4) x4_log.push_back(opcode4);
    endtask

    task automatic clear_counts();
        exec_cnt  = 0;
        fetch_cnt = 0;
        done_cnt  = 0;
        exp_q.delete();
        fetch_log.delete();
    endtask

    task automatic load_prog(input vec_t v);
        for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
        for (int i = 0; i < int'(v.n_words); i++) mem[i] = v.prog[i];
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_done(input string name);
        int cyc = 0;
        while (done_cnt == 0 && cyc < 400) begin
            step();
            cyc++;
        end
        check({name, "_done_pulse"}, done_cnt, 1);
        step();
        check({name, "_done_one_cycle"}, 32'(done), 0);
        check({name, "_idle_after_halt"}, 32'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        for (int v = 0; v < NumVecs; v++) vecs[v] = '0;
        vecs[0].prog[0] = 16'hC0A0; vecs[0].prog[1] = 16'h8000; vecs[0].n_words = 2;
        vecs[0].ops[0] = 16'hC0A0; vecs[0].n_ops = 1; vecs[0].n_fetch = 2;

        vecs[1].prog[0] = 16'h1234; vecs[1].prog[1] = 16'h4321; vecs[1].prog[2] = 16'hFFFF;
        vecs[1].prog[3] = 16'h8000; vecs[1].n_words = 4; vecs[1].ack_wait = 1;
        vecs[1].ops[0] = 16'h1234; vecs[1].ops[1] = 16'h4321; vecs[1].ops[2] = 16'hFFFF;
        vecs[1].n_ops = 3; vecs[1].n_fetch = 4;

        vecs[2].prog[0] = 16'h9003; vecs[2].prog[1] = 16'h1111; vecs[2].prog[2] = 16'h2222;
        vecs[2].prog[3] = 16'h3333; vecs[2].prog[4] = 16'h8000; vecs[2].n_words = 5;
        vecs[2].ops[0] = 16'h3333; vecs[2].n_ops = 1; vecs[2].n_fetch = 3;

        vecs[3].prog[0] = 16'hA003; vecs[3].prog[1] = 16'hC010; vecs[3].prog[2] = 16'hB001;
        vecs[3].prog[3] = 16'h8000; vecs[3].n_words = 4;
        for (int k = 0; k < 4; k++) vecs[3].ops[k] = 16'hC010;
`ifdef SEQ_LOOP_EN
        vecs[3].n_ops = 4; vecs[3].n_fetch = 10;
`else
        vecs[3].n_ops = 1; vecs[3].n_fetch = 4;
`endif

        // Second LOOP_SET overwrites the counter with 0, so LOOP_BACK falls through.
        vecs[4].prog[0] = 16'hA002; vecs[4].prog[1] = 16'hA000; vecs[4].prog[2] = 16'hC022;
        vecs[4].prog[3] = 16'hB002; vecs[4].prog[4] = 16'h8000; vecs[4].n_words = 5;
        vecs[4].ack_wait = 2; vecs[4].ops[0] = 16'hC022; vecs[4].n_ops = 1; vecs[4].n_fetch = 5;

        vecs[5].prog[0] = 16'h8000; vecs[5].n_words = 1; vecs[5].n_ops = 0; vecs[5].n_fetch = 1;

        ack_wait = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
        for (int i = 0; i < 16; i++) mem4[i] = 16'h8000;

        // Reset state
        #3;
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_execute_done", 32'({execute, done}), 0);
        check("rst_opcode", 32'(opcode), 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        for (int i = 0; i < 5; i++) step();
        check("idle_no_fetch", fetch_cnt, 0);
        check("idle_not_busy", 32'(busy), 0);

        for (int v = 0; v < NumVecs; v++) begin
            load_prog(vecs[v]);
            ack_wait = int'(vecs[v].ack_wait);
            clear_counts();
            for (int k = 0; k < int'(vecs[v].n_ops); k++) exp_q.push_back(vecs[v].ops[k]);
            pulse_start();
            run_to_done($sformatf("v%0d", v));
            check($sformatf("v%0d_exec_count", v), exec_cnt, 32'(vecs[v].n_ops));
            check($sformatf("v%0d_fetch_count", v), fetch_cnt, 32'(vecs[v].n_fetch));
            check($sformatf("v%0d_first_addr", v), 32'(fetch_log[0]), 0);
            check($sformatf("v%0d_sb_empty", v), exp_q.size(), 0);
        end

        // Stall for 5 ISSUE cycles; a start pulse mid-stall must be ignored.
        for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
        mem[0] = 16'h4455;
        ack_wait = 0;
        clear_counts();
        exp_q.push_back(16'h4455);
        pulse_start();
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            start = (k == 1);
            step();
            check($sformatf("stall_c%0d_no_exec", k), 32'(execute), 0);
            check($sformatf("stall_c%0d_no_req", k), 32'(imem_req), 0);
        end
        start = 1'b0;
        stall = 1'b0;
        step();
        check("stall_release_exec", 32'(execute), 1);
        check("stall_pc_once", 32'(imem_addr), 1);
        run_to_done("stall");
        check("stall_exec_count", exec_cnt, 1);
        check("stall_fetch_count", fetch_cnt, 2);

        // Reset during a 3-cycle ack wait
        for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
        mem[0] = 16'h1111;
        ack_wait = 3;
        clear_counts();
        pulse_start();
        step();
        check("pre_rst_req_pending", 32'(imem_req && !imem_ack), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", 32'(imem_req), 0);
        check("async_rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) step();
        check("post_rst_no_exec", exec_cnt, 0);
        check("post_rst_no_fetch", fetch_cnt, 0);
        check("post_rst_req_low", 32'(imem_req), 0);
        ack_wait = 0;
        clear_counts();
        exp_q.push_back(16'h1111);
        pulse_start();
        check("restart_addr0", 32'(fetch_log[0]), 0);
        run_to_done("restart");
        check("restart_exec_count", exec_cnt, 1);

        // Address wrap at ADDR_WIDTH=4: JUMP 15, then array instruction at 15.
        mem4[0] = 16'h900F;
        mem4[15] = 16'h1234;
        f4_log.delete();
        x4_log.delete();
        rst4_n = 1'b1;
        step();
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        for (int k = 0; k < 20 && f4_log.size() < 3; k++) step();
        check("wrap_fetches_seen", 32'(f4_log.size() >= 3), 1);
        check("wrap_jump_addr", 32'(f4_log[1]), 15);
        check("wrap_next_addr", 32'(f4_log[2]), 0);
        check("wrap_exec_opcode", 32'(x4_log[0]), 32'h1234);
        rst4_n = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
